regfile_wb_scheduler: RTL and testbench

- Shares the register file's single write port between NREQ writeback sources: ALU, LSU, MULDIV and CSR.
- Uses round-robin arbitration with per-source valid/ready handshakes.
- Keeps a busy scoreboard of destination registers so that issue logic can stall on RAW/WAW hazards.
- Sits between the execute/memory units and the register file, and drives the file's we/wa/wd inputs directly.

---
 rtl/core_config_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/regfile_wb_scheduler.sv | 110 +++++++++++
 tb/tb_regfile_wb_scheduler.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_config_pkg.sv
// Core-wide configuration: widths, register count and
// writeback source encoding shared by execute-side units.
package core_config_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;
  localparam int WB_NREQ    = 4;

  typedef enum logic [1:0] {
    WB_ALU    = 2'd0,
    WB_LSU    = 2'd1,
    WB_MULDIV = 2'd2,
    WB_CSR    = 2'd3
  } wb_src_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer
// advances past the winner. Ports: clk, rst_n, en, req, grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] idx;
  logic          hit;

  // Scan ptr, ptr+1, ... modulo N; first requester wins.
  always_comb begin
    grant = '0;
    gidx  = ptr;
    idx   = '0;
    hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!hit && req[idx]) begin
        hit  = 1'b1;
        gidx = idx;
      end
    end
    if (en && hit) grant[gidx] = 1'b1;
  end

  // A grant implies a transfer since grant requires req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en && hit) begin
      if (int'(gidx) == N - 1) ptr <= '0;
      else                     ptr <= gidx + PW'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register file write port between writeback
// sources and tracks pending destinations for hazard checks.
// Ports: req_* handshake per source, issue_*/rs*/flush for the
// scoreboard, *_busy queries, registered rf_we/rf_wa/rf_wd.
module regfile_wb_scheduler
  import core_config_pkg::*;
#(
  parameter int NREQ       = WB_NREQ,
  parameter int XLEN_P     = XLEN,
  parameter int REG_ADDR_W_P = REG_ADDR_W,
  parameter int REG_COUNT_P  = REG_COUNT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk_en,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*REG_ADDR_W_P-1:0] req_rd,
  input  logic [NREQ*XLEN_P-1:0]       req_data,
  output logic [NREQ-1:0]              req_ready,
  input  logic                         issue_valid,
  input  logic [REG_ADDR_W_P-1:0]      issue_rd,
  input  logic [REG_ADDR_W_P-1:0]      rs1,
  input  logic [REG_ADDR_W_P-1:0]      rs2,
  output logic                         rs1_busy,
  output logic                         rs2_busy,
  output logic                         rd_busy,
  input  logic                         flush,
  output logic                         rf_we,
  output logic [REG_ADDR_W_P-1:0]      rf_wa,
  output logic [XLEN_P-1:0]            rf_wd
);

  localparam int AW = REG_ADDR_W_P;
  localparam int DW = XLEN_P;

  logic [NREQ-1:0]        grant;
  logic                   xfer;
  logic [AW-1:0]          sel_rd;
  logic [DW-1:0]          sel_data;
  logic [REG_COUNT_P-1:0] busy;
  logic [REG_COUNT_P-1:0] busy_nxt;

  // Reset also masks grants so no source sees ready in reset.
  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (clk_en & rst_n),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  // One-hot grant -> and-or mux of the winning payload.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_rd   = req_rd[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (clk_en) begin
      if (xfer) begin
        rf_we <= (sel_rd != '0);
        rf_wa <= sel_rd;
        rf_wd <= sel_data;
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

  // Clear lands with the file write; a new producer's set
  // overrides it; flush overrides everything.
  always_comb begin
    busy_nxt = busy;
    if (rf_we) busy_nxt[rf_wa] = 1'b0;
    if (issue_valid && issue_rd != '0)
      busy_nxt[issue_rd] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      busy <= '0;
    else if (clk_en) busy <= busy_nxt;
  end

  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];
  assign rd_busy  = busy[issue_rd];

  a_no_waw : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(clk_en && issue_valid && rd_busy && !flush)
  );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed self-checking bench for regfile_wb_scheduler.
// One task per scenario; expected values are hand-derived.
module tb_regfile_wb_scheduler;

  logic         clk;
  logic         rst_n;
  logic         clk_en;
  logic [3:0]   req_valid;
  logic [19:0]  req_rd;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic [4:0]   rs1;
  logic [4:0]   rs2;
  logic         rs1_busy;
  logic         rs2_busy;
  logic         rd_busy;
  logic         flush;
  logic         rf_we;
  logic [4:0]   rf_wa;
  logic [31:0]  rf_wd;

  int n_chk;
  int n_fail;

  regfile_wb_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rd_busy     (rd_busy),
    .flush       (flush),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [4:0] rd,
                         input logic [31:0] d);
    req_rd[i*5 +: 5]    = rd;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic test_reset;
    #2;
    n_chk++;
    if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_rf we=%b wa=%0d wd=%h want 0/0/0",
               rf_we, rf_wa, rf_wd);
    end
    n_chk++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready got=%b want=0000", req_ready);
    end
    n_chk++;
    if ({rs1_busy, rs2_busy, rd_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_busy got=%b want=000",
               {rs1_busy, rs2_busy, rd_busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin;
    int exp_g[8] = '{0, 1, 2, 3, 0, 2, 3, 0};
    for (int i = 0; i < 4; i++) set_src(i, 5'(10 + i), 32'h100 + i);
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) req_valid = 4'b1101;
      #1;
      n_chk++;
      if (req_ready !== (4'b0001 << exp_g[i])) begin
        n_fail++;
        $display("FAIL rr_grant[%0d] got=%b want=%b", i,
                 req_ready, 4'b0001 << exp_g[i]);
      end
      tick();
      n_chk++;
      if (rf_we !== 1'b1 || rf_wa !== 5'(10 + exp_g[i]) ||
          rf_wd !== 32'h100 + exp_g[i]) begin
        n_fail++;
        $display("FAIL rr_write[%0d] we=%b wa=%0d wd=%h want 1/%0d/%h",
                 i, rf_we, rf_wa, rf_wd, 10 + exp_g[i],
                 32'h100 + exp_g[i]);
      end
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_single_write;
    rs1 = 5'd5;
    issue_valid = 1'b1;
    issue_rd = 5'd5;
    #1;
    n_chk++;
    if (rs1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_pre_busy got=%b want=0", rs1_busy);
    end
    tick();
    issue_valid = 1'b0;
    set_src(1, 5'd5, 32'hDEADBEEF);
    req_valid = 4'b0010;
    #1;
    n_chk++;
    if (rs1_busy !== 1'b1 || req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL sw_issue busy=%b ready=%b want 1/0010",
               rs1_busy, req_ready);
    end
    tick();
    req_valid = 4'b0000;
    n_chk++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd5 ||
        rf_wd !== 32'hDEADBEEF || rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_write we=%b wa=%0d wd=%h busy=%b want 1/5/deadbeef/1",
               rf_we, rf_wa, rf_wd, rs1_busy);
    end
    tick();
    n_chk++;
    if (rs1_busy !== 1'b0 || rf_we !== 1'b0 || rf_wa !== 5'd5) begin
      n_fail++;
      $display("FAIL sw_clear busy=%b we=%b wa=%0d want 0/0/5",
               rs1_busy, rf_we, rf_wa);
    end
  endtask

  task automatic test_x0_clk_en;
    set_src(0, 5'd0, 32'h1234);
    req_valid = 4'b0001;
    rs1 = 5'd0;
    #1;
    n_chk++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL x0_ready got=%b want=0001", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    n_chk++;
    if (rf_we !== 1'b0 || rf_wa !== 5'd0 ||
        rf_wd !== 32'h1234 || rs1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_write we=%b wa=%0d wd=%h busy=%b want 0/0/1234/0",
               rf_we, rf_wa, rf_wd, rs1_busy);
    end
    for (int i = 0; i < 4; i++) set_src(i, 5'(10 + i), 32'h200 + i);
    req_valid = 4'b1111;
    clk_en = 1'b0;
    issue_valid = 1'b1;
    issue_rd = 5'd20;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++;
      if (req_ready !== 4'b0000 || rf_we !== 1'b0 ||
          rf_wd !== 32'h1234) begin
        n_fail++;
        $display("FAIL freeze[%0d] ready=%b we=%b wd=%h want 0000/0/1234",
                 c, req_ready, rf_we, rf_wd);
      end
      tick();
    end
    issue_valid = 1'b0;
    rs1 = 5'd20;
    #1;
    n_chk++;
    if (rs1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_set got=%b want=0", rs1_busy);
    end
    clk_en = 1'b1;
    #1;
    n_chk++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL resume_ptr got=%b want=0010", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    n_chk++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd11 || rf_wd !== 32'h201) begin
      n_fail++;
      $display("FAIL resume_write we=%b wa=%0d wd=%h want 1/11/201",
               rf_we, rf_wa, rf_wd);
    end
    tick();
  endtask

  task automatic test_collision;
    set_src(3, 5'd7, 32'h77);
    req_valid = 4'b1000;
    rs1 = 5'd7;
    #1;
    n_chk++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL col_ready got=%b want=1000", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    issue_valid = 1'b1;
    issue_rd = 5'd7;
    #1;
    n_chk++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rd_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL col_pre we=%b wa=%0d rd_busy=%b want 1/7/0",
               rf_we, rf_wa, rd_busy);
    end
    tick();
    issue_valid = 1'b0;
    n_chk++;
    if (rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL col_set_wins got=%b want=1", rs1_busy);
    end
    set_src(2, 5'd7, 32'h78);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    n_chk++;
    if (rf_we !== 1'b1 || rf_wd !== 32'h78 || rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL col_write we=%b wd=%h busy=%b want 1/78/1",
               rf_we, rf_wd, rs1_busy);
    end
    tick();
    n_chk++;
    if (rs1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL col_clear got=%b want=0", rs1_busy);
    end
  endtask

  task automatic test_flush;
    rs1 = 5'd3;
    rs2 = 5'd9;
    issue_valid = 1'b1;
    issue_rd = 5'd3;
    tick();
    issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    set_src(0, 5'd3, 32'hCAFE);
    req_valid = 4'b0001;
    #1;
    n_chk++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1 ||
        req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL fl_pre b1=%b b2=%b ready=%b want 1/1/0001",
               rs1_busy, rs2_busy, req_ready);
    end
    tick();
    req_valid = 4'b0000;
    flush = 1'b1;
    issue_valid = 1'b1;
    issue_rd = 5'd12;
    #1;
    n_chk++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'hCAFE) begin
      n_fail++;
      $display("FAIL fl_inflight we=%b wa=%0d wd=%h want 1/3/cafe",
               rf_we, rf_wa, rf_wd);
    end
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    #1;
    n_chk++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_clear b1=%b b2=%b we=%b want 0/0/0",
               rs1_busy, rs2_busy, rf_we);
    end
    rs1 = 5'd12;
    #1;
    n_chk++;
    if (rs1_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_drop_set got=%b want=0", rs1_busy);
    end
    rs1 = 5'd3;
    tick();
    n_chk++;
    if (rs1_busy !== 1'b0 || rf_wd !== 32'hCAFE) begin
      n_fail++;
      $display("FAIL fl_after busy=%b wd=%h want 0/cafe",
               rs1_busy, rf_wd);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) set_src(i, 5'(10 + i), 32'h300 + i);
    req_valid = 4'b1111;
    issue_valid = 1'b1;
    issue_rd = 5'd15;
    rs1 = 5'd15;
    tick();
    issue_valid = 1'b0;
    #1;
    n_chk++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd11 || rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_pre we=%b wa=%0d busy=%b want 1/11/1",
               rf_we, rf_wa, rs1_busy);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0 ||
        req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL rm_async we=%b wa=%0d wd=%h ready=%b want 0/0/0/0000",
               rf_we, rf_wa, rf_wd, req_ready);
    end
    n_chk++;
    if ({rs1_busy, rs2_busy, rd_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL rm_busy got=%b want=000",
               {rs1_busy, rs2_busy, rd_busy});
    end
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    clk_en = 1'b1;
    req_valid = '0;
    req_rd = '0;
    req_data = '0;
    issue_valid = 1'b0;
    issue_rd = '0;
    rs1 = '0;
    rs2 = '0;
    flush = 1'b0;
    test_reset();
    test_round_robin();
    test_single_write();
    test_x0_clk_en();
    test_collision();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout sim_time=%0t limit=100000", $time);
    $fatal(1);
  end

endmodule
